// File: rtl/nn_pe_pkg.sv
// Shared types and helpers for the systolic MAC processing element.
package nn_pe_pkg;

   // Widest value the narrowing helper can take in.
   localparam int unsigned MaxW = 128;

   // Dot-product sequencing state.
   typedef enum logic [0:0] {
      StIdle,  // no dot product in progress
      StAcc    // accumulating a dot product
   } pe_state_t;

   // The accumulator must hold a full product and fit the narrowing helper.
   function automatic bit acc_w_ok(input int unsigned data_w, input int unsigned acc_w);
      return (acc_w >= 2 * data_w) && (acc_w < MaxW);
   endfunction

   // The drain result must not be wider than the accumulator.
   function automatic bit out_w_ok(input int unsigned out_w, input int unsigned acc_w);
      return (out_w >= 2) && (out_w <= acc_w);
   endfunction

   // Signed clamp of val into a to_w-bit range. The return value is the clamped
   // number sign-extended to MaxW; ovf reports that clamping happened.
   function automatic logic signed [MaxW-1:0] sat_narrow(
      input  logic signed [MaxW-1:0] val,
      input  int unsigned            to_w,
      output logic                   ovf
   );
      logic signed [MaxW-1:0] one;
      logic signed [MaxW-1:0] hi;
      logic signed [MaxW-1:0] lo;
      one = 1;
      hi  = (one <<< (to_w - 1)) - one;
      lo  = ~hi;
      ovf = (val > hi) || (val < lo);
      if (val > hi) begin
         return hi;
      end
      if (val < lo) begin
         return lo;
      end
      return val;
   endfunction

endpackage

// File: rtl/pe_result_slot.sv
// One-entry pending result register feeding a per-column drain chain.
// Upstream results always win the chain; the local result waits for a gap.
module pe_result_slot
#(
   parameter int unsigned OUT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic signed [OUT_W-1:0] load_data,
   input  logic signed [OUT_W-1:0] res_in,
   input  logic                    res_valid_in,
   output logic signed [OUT_W-1:0] res_out,
   output logic                    res_valid_out,
   output logic                    drop_err
);
   import nn_pe_pkg::*;

   logic                    pend_q;
   logic                    pend_d;
   logic signed [OUT_W-1:0] slot_q;
   logic signed [OUT_W-1:0] slot_d;
   logic                    drain;
   logic                    drop;

   // Slot next-state: a drain and a refill at the same edge is a legal hand-off.
   always_comb begin
      drain  = pend_q & ~res_valid_in;
      pend_d = pend_q & ~drain;
      slot_d = slot_q;
      drop   = 1'b0;
      if (load) begin
         pend_d = 1'b1;
         slot_d = load_data;
         drop   = pend_q & ~drain;
      end
   end

   // Slot state, drain mux and sticky drop flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q        <= 1'b0;
         slot_q        <= '0;
         res_out       <= '0;
         res_valid_out <= 1'b0;
         drop_err      <= 1'b0;
      end else begin
         pend_q <= pend_d;
         slot_q <= slot_d;
         if (drop) begin
            drop_err <= 1'b1;
         end
         if (res_valid_in) begin
            res_out       <= res_in;
            res_valid_out <= 1'b1;
         end else if (pend_q) begin
            res_out       <= slot_q;
            res_valid_out <= 1'b1;
         end else begin
            res_valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary MAC processing element for the systolic NN array.
// Activations flow east, weights flow south, finished dot products are scaled,
// narrowed and handed to the per-column drain chain.
module systolic_mac_pe
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned ACC_W      = 40,
   parameter int unsigned OUT_W      = 32,
   parameter int unsigned FRAC_SHIFT = 0,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] a_in,
   input  logic                     a_valid_in,
   input  logic                     first_in,
   input  logic                     last_in,
   input  logic signed [DATA_W-1:0] b_in,
   input  logic                     b_valid_in,
   output logic signed [DATA_W-1:0] a_out,
   output logic                     a_valid_out,
   output logic                     first_out,
   output logic                     last_out,
   output logic signed [DATA_W-1:0] b_out,
   output logic                     b_valid_out,
   input  logic signed [OUT_W-1:0]  res_in,
   input  logic                     res_valid_in,
   output logic signed [OUT_W-1:0]  res_out,
   output logic                     res_valid_out,
   output logic                     skew_err,
   output logic                     seq_err,
   output logic                     drop_err,
   output logic                     ovf
);
   import nn_pe_pkg::*;

   localparam int unsigned ProdW    = 2 * DATA_W;
   localparam bit          ParamsOk = acc_w_ok(DATA_W, ACC_W) && out_w_ok(OUT_W, ACC_W);
   localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W - 1) {1'b1}}};
   localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W - 1) {1'b0}}};

   pe_state_t               state_q;
   logic signed [ACC_W-1:0] acc_q;

   logic                    fire;
   logic                    start;
   logic signed [ProdW-1:0] prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W:0]   sum_wide;
   logic signed [ACC_W-1:0] acc_next;
   logic                    add_ovf;
   logic signed [ACC_W-1:0] shifted;
   logic signed [MaxW-1:0]  narrow_full;
   logic                    narrow_ovf;
   logic signed [OUT_W-1:0] res_val;
   logic                    res_load;
   logic                    unused_narrow_hi;

   // Multiply, accumulate with overflow handling, then scale and narrow.
   always_comb begin
      fire     = a_valid_in & b_valid_in;
      // A fire in IDLE always opens a new sum, marked or not.
      start    = first_in | (state_q == StIdle);
      prod     = ProdW'(a_in) * ProdW'(b_in);
      prod_ext = ACC_W'(prod);
      // One guard bit exposes overflow of the accumulate.
      sum_wide = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(prod_ext);
      add_ovf  = 1'b0;
      if (start) begin
         acc_next = prod_ext;
      end else if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
         add_ovf = 1'b1;
         if (SATURATE) begin
            acc_next = sum_wide[ACC_W] ? AccMin : AccMax;
         end else begin
            acc_next = sum_wide[ACC_W-1:0];
         end
      end else begin
         acc_next = sum_wide[ACC_W-1:0];
      end

      shifted     = acc_next >>> FRAC_SHIFT;
      narrow_ovf  = 1'b0;
      narrow_full = sat_narrow(MaxW'(shifted), OUT_W, narrow_ovf);
      // In wrap mode a truncation that changes the value still counts as an overflow.
      res_val     = SATURATE ? narrow_full[OUT_W-1:0] : shifted[OUT_W-1:0];
      res_load    = fire & last_in;
   end

   assign unused_narrow_hi = ^narrow_full[MaxW-1:OUT_W];

   // Forwarding registers, accumulator, sequencing FSM and sticky error flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         a_out       <= '0;
         a_valid_out <= 1'b0;
         first_out   <= 1'b0;
         last_out    <= 1'b0;
         b_out       <= '0;
         b_valid_out <= 1'b0;
         skew_err    <= 1'b0;
         seq_err     <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         a_out       <= a_in;
         a_valid_out <= a_valid_in;
         first_out   <= first_in;
         last_out    <= last_in;
         b_out       <= b_in;
         b_valid_out <= b_valid_in;
         if (a_valid_in ^ b_valid_in) begin
            skew_err <= 1'b1;
         end
         if (fire) begin
            acc_q   <= acc_next;
            state_q <= last_in ? StIdle : StAcc;
            if (!first_in && (state_q == StIdle)) begin
               seq_err <= 1'b1;
            end
            if (add_ovf || (res_load && narrow_ovf)) begin
               ovf <= 1'b1;
            end
         end
      end
   end

   // Illegal width combinations are caught in simulation.
   always_ff @(posedge clk) begin
      assert (ParamsOk) else $error("systolic_mac_pe: illegal DATA_W/ACC_W/OUT_W");
   end

   pe_result_slot #(
      .OUT_W (OUT_W)
   ) u_result_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .load          (res_load),
      .load_data     (res_val),
      .res_in        (res_in),
      .res_valid_in  (res_valid_in),
      .res_out       (res_out),
      .res_valid_out (res_valid_out),
      .drop_err      (drop_err)
   );

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: four differently parameterised PEs share one
// stimulus stream and are checked every cycle against an arithmetic model.
module tb_systolic_mac_pe;

   localparam int AccW  [4] = '{40, 32, 32, 40};
   localparam int OutW  [4] = '{32, 32, 32, 20};
   localparam int Shift [4] = '{0, 0, 0, 3};
   localparam bit Sat   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [15:0] a_in, b_in;
   logic               a_valid_in, b_valid_in, first_in, last_in, res_valid_in;
   logic        [31:0] res_in;

   logic signed [15:0] a_out_w [4];
   logic signed [15:0] b_out_w [4];
   logic av_o [4], bv_o [4], f_o [4], l_o [4], rv_o [4];
   logic skew_o [4], seq_o [4], drop_o [4], ovf_o [4];
   logic signed [31:0] r0, r1, r2;
   logic signed [19:0] r3;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state
   longint             acc [4], slot [4], e_res [4];
   bit                 insum [4], pend [4], e_rv [4];
   bit                 e_skew [4], e_seq [4], e_drop [4], e_ovf [4];
   logic signed [15:0] e_a, e_b;
   bit                 e_av, e_bv, e_f, e_l;

   always #5 clk = ~clk;

   systolic_mac_pe #(.DATA_W(16), .ACC_W(40), .OUT_W(32), .FRAC_SHIFT(0), .SATURATE(1'b1)) u_d0 (
      .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in),
      .last_in(last_in), .b_in(b_in), .b_valid_in(b_valid_in), .a_out(a_out_w[0]),
      .a_valid_out(av_o[0]), .first_out(f_o[0]), .last_out(l_o[0]), .b_out(b_out_w[0]),
      .b_valid_out(bv_o[0]), .res_in(res_in), .res_valid_in(res_valid_in), .res_out(r0),
      .res_valid_out(rv_o[0]), .skew_err(skew_o[0]), .seq_err(seq_o[0]),
      .drop_err(drop_o[0]), .ovf(ovf_o[0]));

   systolic_mac_pe #(.DATA_W(16), .ACC_W(32), .OUT_W(32), .FRAC_SHIFT(0), .SATURATE(1'b1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in),
      .last_in(last_in), .b_in(b_in), .b_valid_in(b_valid_in), .a_out(a_out_w[1]),
      .a_valid_out(av_o[1]), .first_out(f_o[1]), .last_out(l_o[1]), .b_out(b_out_w[1]),
      .b_valid_out(bv_o[1]), .res_in(res_in), .res_valid_in(res_valid_in), .res_out(r1),
      .res_valid_out(rv_o[1]), .skew_err(skew_o[1]), .seq_err(seq_o[1]),
      .drop_err(drop_o[1]), .ovf(ovf_o[1]));

   systolic_mac_pe #(.DATA_W(16), .ACC_W(32), .OUT_W(32), .FRAC_SHIFT(0), .SATURATE(1'b0)) u_d2 (
      .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in),
      .last_in(last_in), .b_in(b_in), .b_valid_in(b_valid_in), .a_out(a_out_w[2]),
      .a_valid_out(av_o[2]), .first_out(f_o[2]), .last_out(l_o[2]), .b_out(b_out_w[2]),
      .b_valid_out(bv_o[2]), .res_in(res_in), .res_valid_in(res_valid_in), .res_out(r2),
      .res_valid_out(rv_o[2]), .skew_err(skew_o[2]), .seq_err(seq_o[2]),
      .drop_err(drop_o[2]), .ovf(ovf_o[2]));

   systolic_mac_pe #(.DATA_W(16), .ACC_W(40), .OUT_W(20), .FRAC_SHIFT(3), .SATURATE(1'b1)) u_d3 (
      .clk(clk), .rst_n(rst_n), .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in),
      .last_in(last_in), .b_in(b_in), .b_valid_in(b_valid_in), .a_out(a_out_w[3]),
      .a_valid_out(av_o[3]), .first_out(f_o[3]), .last_out(l_o[3]), .b_out(b_out_w[3]),
      .b_valid_out(bv_o[3]), .res_in(res_in[19:0]), .res_valid_in(res_valid_in), .res_out(r3),
      .res_valid_out(rv_o[3]), .skew_err(skew_o[3]), .seq_err(seq_o[3]),
      .drop_err(drop_o[3]), .ovf(ovf_o[3]));

   // Two's-complement wrap of x into w bits.
   function automatic longint wrapw(input longint x, input int w);
      longint t;
      t = x <<< (64 - w);
      return t >>> (64 - w);
   endfunction

   // Fit x into w signed bits by clamping or wrapping; o reports out-of-range.
   function automatic longint fit(input longint x, input int w, input bit sat, output bit o);
      longint hi, lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      o  = (x > hi) || (x < lo);
      if (!o) return x;
      if (sat) return (x > hi) ? hi : lo;
      return wrapw(x, w);
   endfunction

   function automatic logic signed [63:0] res_of(input int d);
      case (d)
         0:       return r0;
         1:       return r1;
         2:       return r2;
         default: return r3;
      endcase
   endfunction

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_step();
      bit     fire, drained, o;
      longint p, nacc, r;
      if (!rst_n) begin
         e_a = '0; e_b = '0; e_av = 0; e_bv = 0; e_f = 0; e_l = 0;
         for (int d = 0; d < 4; d++) begin
            acc[d] = 0; slot[d] = 0; e_res[d] = 0; insum[d] = 0; pend[d] = 0; e_rv[d] = 0;
            e_skew[d] = 0; e_seq[d] = 0; e_drop[d] = 0; e_ovf[d] = 0;
         end
      end else begin
         fire = a_valid_in & b_valid_in;
         e_a = a_in; e_b = b_in; e_av = a_valid_in; e_bv = b_valid_in;
         e_f = first_in; e_l = last_in;
         for (int d = 0; d < 4; d++) begin
            if (a_valid_in != b_valid_in) e_skew[d] = 1;
            drained = 0;
            if (res_valid_in) begin
               e_res[d] = wrapw(longint'($signed(res_in)), OutW[d]);
               e_rv[d]  = 1;
            end else if (pend[d]) begin
               e_res[d] = slot[d];
               e_rv[d]  = 1;
               drained  = 1;
            end else begin
               e_rv[d] = 0;
            end
            if (drained) pend[d] = 0;
            if (fire) begin
               p = longint'(a_in) * longint'(b_in);
               if (first_in || !insum[d]) begin
                  if (!first_in) e_seq[d] = 1;
                  nacc = p;
               end else begin
                  nacc = fit(acc[d] + p, AccW[d], Sat[d], o);
                  if (o) e_ovf[d] = 1;
               end
               acc[d]   = nacc;
               insum[d] = !last_in;
               if (last_in) begin
                  r = fit(nacc >>> Shift[d], OutW[d], Sat[d], o);
                  if (o) e_ovf[d] = 1;
                  if (pend[d]) e_drop[d] = 1;
                  slot[d] = r;
                  pend[d] = 1;
               end
            end
         end
      end
   endtask

   task automatic chk(input int d, input string name, input logic signed [63:0] act,
                      input longint want);
      n_cmp++;
      if (act !== 64'(want)) begin
         n_bad++;
         $display("FAIL d%0d %s: got %0d, want %0d", d, name, act, want);
      end
   endtask

   task automatic compare_all();
      for (int d = 0; d < 4; d++) begin
         chk(d, "a_out", a_out_w[d], e_a);
         chk(d, "b_out", b_out_w[d], e_b);
         chk(d, "a_valid_out", av_o[d], e_av);
         chk(d, "b_valid_out", bv_o[d], e_bv);
         chk(d, "first_out", f_o[d], e_f);
         chk(d, "last_out", l_o[d], e_l);
         chk(d, "res_valid_out", rv_o[d], e_rv[d]);
         if (e_rv[d]) chk(d, "res_out", res_of(d), e_res[d]);
         chk(d, "skew_err", skew_o[d], e_skew[d]);
         chk(d, "seq_err", seq_o[d], e_seq[d]);
         chk(d, "drop_err", drop_o[d], e_drop[d]);
         chk(d, "ovf", ovf_o[d], e_ovf[d]);
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input bit av, input bit bv, input int a, input int b, input bit f,
                        input bit l, input bit rv = 0, input int r = 0);
      a_valid_in = av; b_valid_in = bv; a_in = 16'(a); b_in = 16'(b);
      first_in = f; last_in = l; res_valid_in = rv; res_in = 32'(r);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      step();
      rst_n = 1'b1;
   endtask

   function automatic int rand_op();
      case ($urandom_range(7))
         0:       return 32767;
         1:       return -32768;
         2, 3:    return int'($urandom_range(40)) - 20;
         default: return int'($urandom_range(65535)) - 32768;
      endcase
   endfunction

   initial begin
      bit both;
      drive(0, 0, 0, 0, 0, 0);
      do_reset();
      do_reset();

      // Dot product {3,-4,5}.{2,6,-1} = -23
      drive(1, 1, 3, 2, 1, 0);  step();
      chk(0, "dot a_out", a_out_w[0], 3);
      chk(0, "dot b_out", b_out_w[0], 2);
      drive(1, 1, -4, 6, 0, 0); step();
      drive(1, 1, 5, -1, 0, 1); step();
      chk(0, "dot valid early", rv_o[0], 0);
      drive(0, 0, 0, 0, 0, 0);  step();
      chk(0, "dot valid", rv_o[0], 1);
      chk(0, "dot res", res_of(0), -23);
      chk(3, "dot res scaled", res_of(3), -3);
      step();
      chk(0, "dot valid after", rv_o[0], 0);

      // Five fires of 32767*32767: saturate, wrap, narrow
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 32767, 32767, i == 0, i == 4);
         step();
      end
      drive(0, 0, 0, 0, 0, 0); step();
      chk(0, "sat40 res", res_of(0), 2147483647);
      chk(1, "sat32 res", res_of(1), 2147483647);
      chk(2, "wrap32 res", res_of(2), 1073414149);
      chk(3, "sat20 res", res_of(3), 524287);
      for (int d = 0; d < 4; d++) chk(d, "sat ovf", ovf_o[d], 1);

      // Drain collision: upstream first, local 7 after the gap
      do_reset();
      drive(1, 1, 7, 1, 1, 1, 1, 100); step();
      chk(0, "coll up0", res_of(0), 100);
      drive(0, 0, 0, 0, 0, 0, 1, 101); step();
      chk(0, "coll up1", res_of(0), 101);
      drive(0, 0, 0, 0, 0, 0, 1, 102); step();
      chk(0, "coll up2", res_of(0), 102);
      drive(0, 0, 0, 0, 0, 0); step();
      chk(0, "coll local", res_of(0), 7);
      chk(0, "coll drop", drop_o[0], 0);

      // Overwrite while upstream holds the chain
      do_reset();
      drive(1, 1, 1, 1, 1, 1, 1, 50); step();
      drive(1, 1, 2, 2, 1, 1, 1, 51); step();
      drive(0, 0, 0, 0, 0, 0, 1, 52); step();
      drive(0, 0, 0, 0, 0, 0); step();
      chk(0, "ovw res", res_of(0), 4);
      chk(0, "ovw drop", drop_o[0], 1);

      // Skew leaves the accumulator alone: 2*3 + 1*1 = 7
      do_reset();
      drive(1, 1, 2, 3, 1, 0); step();
      drive(1, 0, 100, 0, 0, 0); step();
      chk(0, "skew flag", skew_o[0], 1);
      drive(1, 1, 1, 1, 0, 1); step();
      drive(0, 0, 0, 0, 0, 0); step();
      chk(0, "skew res", res_of(0), 7);

      // Fire without first in IDLE
      do_reset();
      drive(1, 1, 6, 7, 0, 1); step();
      chk(0, "seq flag", seq_o[0], 1);
      drive(0, 0, 0, 0, 0, 0); step();
      chk(0, "seq res", res_of(0), 42);

      // Reset in the middle of a sum
      do_reset();
      drive(1, 1, 10, 10, 1, 0); step();
      rst_n = 1'b0;
      drive(1, 1, 55, 55, 1, 1); step();
      rst_n = 1'b1;
      chk(0, "rst a_out", a_out_w[0], 0);
      chk(0, "rst a_valid_out", av_o[0], 0);
      chk(0, "rst res_out", res_of(0), 0);
      chk(0, "rst res_valid_out", rv_o[0], 0);
      drive(1, 1, 1, 1, 0, 1); step();
      chk(0, "rst seq", seq_o[0], 1);
      drive(0, 0, 0, 0, 0, 0); step();
      chk(0, "rst res", res_of(0), 1);

      // Randomised traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(199) != 0);
         both  = ($urandom_range(99) < 85);
         drive(both ? 1'b1 : 1'($urandom_range(1)), both ? 1'b1 : 1'($urandom_range(1)),
               rand_op(), rand_op(), $urandom_range(99) < 15, $urandom_range(99) < 25,
               $urandom_range(99) < 25, int'($urandom));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
